// File: rtl/bus_arb_pkg.sv
// Shared types and parameter limits for the bus host arbiter and its ID FIFO.
package bus_arb_pkg;

    localparam int unsigned MinHosts          = 2;
    localparam int unsigned MaxHosts          = 8;
    localparam int unsigned MinOutstanding    = 1;
    localparam int unsigned MaxOutstandingLim = 8;

    // Index width for a given host count; never collapses to zero bits.
    function automatic int unsigned host_idx_w(input int unsigned nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

    localparam int unsigned HostIdxW = host_idx_w(MaxHosts);

    typedef logic [HostIdxW-1:0] host_idx_t;

    typedef struct packed {
        logic      valid;
        host_idx_t idx;
    } pick_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for granted requests that still await a response.
module bus_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 3,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap explicitly so depths that are not powers of two work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written, and count guards that.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between several hosts,
// routing each response back to its issuer through an in-order ID FIFO.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,

    output logic                    device_req_o,
    input  logic                    device_gnt_i,
    output logic [AddressWidth-1:0] device_addr_o,
    output logic                    device_we_o,
    output logic [DataWidth/8-1:0]  device_be_o,
    output logic [DataWidth-1:0]    device_wdata_o,
    input  logic                    device_rvalid_i,
    input  logic [DataWidth-1:0]    device_rdata_i,
    input  logic                    device_err_i,

    output logic                    busy_o,
    output logic                    unexp_rvalid_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if (NrHosts < MinHosts || NrHosts > MaxHosts) begin : g_bad_nr_hosts
        $error("bus_host_arbiter: NrHosts out of range");
    end
    if (MaxOutstanding < MinOutstanding || MaxOutstanding > MaxOutstandingLim) begin : g_bad_depth
        $error("bus_host_arbiter: MaxOutstanding out of range");
    end

    // Rotate so the priority host sits at bit 0, take the first set bit, rotate the index back.
    function automatic pick_t pick_winner(input logic [NrHosts-1:0] elig, input host_idx_t prio);
        logic [NrHosts-1:0] rot;
        pick_t              res;
        res = '0;
        for (int i = 0; i < NrHosts; i++) begin
            rot[i] = elig[(i + int'(prio)) % NrHosts];
        end
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res.valid = 1'b1;
                res.idx   = host_idx_t'((i + int'(prio)) % NrHosts);
            end
        end
        return res;
    endfunction

    host_idx_t          prio_q, prio_d;
    logic               unexp_q, unexp_d;
    logic [NrHosts-1:0] eligible;
    pick_t              pick;
    logic               grant;
    logic               fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    host_idx_t          fifo_head;
    logic [CntW-1:0]    fifo_count;

    // Eligibility uses only the registered full flag, keeping rvalid off the grant path.
    assign eligible = host_req_i & {NrHosts{!fifo_full}};
    assign pick     = pick_winner(eligible, prio_q);

    assign device_req_o = pick.valid;
    assign grant        = pick.valid && device_gnt_i;
    assign fifo_push    = grant;
    assign fifo_pop     = device_rvalid_i && !fifo_empty;

    always_comb begin
        host_gnt_o     = '0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int i = 0; i < NrHosts; i++) begin
            if (pick.valid && pick.idx == host_idx_t'(i)) begin
                host_gnt_o[i]  = device_gnt_i;
                device_addr_o  = host_addr_i[i];
                device_we_o    = host_we_i[i];
                device_be_o    = host_be_i[i];
                device_wdata_o = host_wdata_i[i];
            end
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int i = 0; i < NrHosts; i++) begin
            host_rdata_o[i] = device_rdata_i;
            if (fifo_pop && fifo_head == host_idx_t'(i)) begin
                host_rvalid_o[i] = 1'b1;
                host_err_o[i]    = device_err_i;
            end
        end
    end

    always_comb begin
        prio_d  = prio_q;
        unexp_d = unexp_q;
        if (grant) begin
            prio_d = (pick.idx == host_idx_t'(NrHosts - 1)) ? '0 : pick.idx + 1'b1;
        end
        if (device_rvalid_i && fifo_empty) begin
            unexp_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q  <= '0;
            unexp_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            unexp_q <= unexp_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (HostIdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (pick.idx),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy_o         = (fifo_count != '0);
    assign unexp_rvalid_o = unexp_q;

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_gnt_o));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full));
    a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_rvalid_o));

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with two hosts and a two-deep ID FIFO.
module tb_bus_host_arbiter;

    localparam int unsigned NrHosts = 2;
    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 32;
    localparam logic [31:0] RdKey   = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NrHosts-1:0] host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [AW-1:0]     host_addr  [NrHosts];
    logic [DW/8-1:0]   host_be    [NrHosts];
    logic [DW-1:0]     host_wdata [NrHosts];
    logic [DW-1:0]     host_rdata [NrHosts];
    logic              dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, busy, unexp;
    logic [AW-1:0]     dev_addr;
    logic [DW/8-1:0]   dev_be;
    logic [DW-1:0]     dev_wdata, dev_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_host_arbiter #(
        .NrHosts        (NrHosts),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (2)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .host_req_i      (host_req),
        .host_gnt_o      (host_gnt),
        .host_addr_i     (host_addr),
        .host_we_i       (host_we),
        .host_be_i       (host_be),
        .host_wdata_i    (host_wdata),
        .host_rvalid_o   (host_rvalid),
        .host_rdata_o    (host_rdata),
        .host_err_o      (host_err),
        .device_req_o    (dev_req),
        .device_gnt_i    (dev_gnt),
        .device_addr_o   (dev_addr),
        .device_we_o     (dev_we),
        .device_be_o     (dev_be),
        .device_wdata_o  (dev_wdata),
        .device_rvalid_i (dev_rvalid),
        .device_rdata_i  (dev_rdata),
        .device_err_i    (dev_err),
        .busy_o          (busy),
        .unexp_rvalid_o  (unexp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rdata, input logic err);
        host_req   = req;
        dev_gnt    = gnt;
        dev_rvalid = rv;
        dev_rdata  = rdata;
        dev_err    = err;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] win_tbl [4];
        logic [1:0] prev;
        win_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_ni        = 1'b0;
        host_addr[0]  = 32'h0000_0100;
        host_addr[1]  = 32'h0000_0200;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_wdata[0] = 32'h1111_0000;
        host_wdata[1] = 32'hCAFE_F00D;
        host_we       = 2'b00;
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_gnt", host_gnt, 0);
        check("rst_dev_req", dev_req, 0);
        check("rst_dev_addr", dev_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_unexp", unexp, 0);
        check("rst_rvalid", host_rvalid, 0);
        next_cycle();

        // Both hosts streaming against a one-cycle RAM: grants alternate, responses follow
        prev = 2'b00;
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, prev != 2'b00, (prev == 2'b10 ? host_addr[1] : host_addr[0]) ^ RdKey, 1'b0);
            @(negedge clk);
            check($sformatf("rr_gnt%0d", c), host_gnt, win_tbl[c]);
            check($sformatf("rr_addr%0d", c), dev_addr, win_tbl[c] == 2'b10 ? host_addr[1] : host_addr[0]);
            check($sformatf("rr_rvalid%0d", c), host_rvalid, prev);
            if (prev != 2'b00) begin
                check($sformatf("rr_rdata%0d", c), host_rdata[prev == 2'b10 ? 1 : 0],
                      (prev == 2'b10 ? host_addr[1] : host_addr[0]) ^ RdKey);
            end
            prev = win_tbl[c];
            next_cycle();
        end
        drive(2'b00, 1'b1, 1'b1, host_addr[1] ^ RdKey, 1'b0);
        @(negedge clk);
        check("rr_last_rvalid", host_rvalid, 2'b10);
        next_cycle();
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rr_idle_busy", busy, 0);
        next_cycle();

        // Give host 1 priority, then stall device_gnt for 3 cycles
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("st_pre_gnt", host_gnt, 2'b01);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        check("st_pre_rvalid", host_rvalid, 2'b01);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check($sformatf("st_gnt%0d", c), host_gnt, 0);
            check($sformatf("st_req%0d", c), dev_req, 1);
            check($sformatf("st_busy%0d", c), busy, 0);
            next_cycle();
        end
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("st_first_gnt", host_gnt, 2'b10);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("st_rvalid", host_rvalid, 2'b10);
        next_cycle();

        // Fill the FIFO, hold rvalid off, then pop while full
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("ff_gnt0", host_gnt, 2'b01);
        next_cycle();
        @(negedge clk);
        check("ff_gnt1", host_gnt, 2'b10);
        next_cycle();
        @(negedge clk);
        check("ff_full_gnt", host_gnt, 0);
        check("ff_full_req", dev_req, 0);
        check("ff_full_addr", dev_addr, 0);
        check("ff_full_busy", busy, 1);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("ff_pop_same_gnt", host_gnt, 0);
        check("ff_pop_rvalid", host_rvalid, 2'b01);
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("ff_pop_next_gnt", host_gnt, 2'b01);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("ff_drain1", host_rvalid, 2'b10);
        next_cycle();
        @(negedge clk);
        check("ff_drain2", host_rvalid, 2'b01);
        next_cycle();

        // Host 1 write, then host 0 read whose response carries an error
        host_we = 2'b10;
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("wr_gnt", host_gnt, 2'b10);
        check("wr_we", dev_we, 1);
        check("wr_wdata", dev_wdata, 32'hCAFE_F00D);
        check("wr_be", dev_be, 4'h3);
        next_cycle();
        host_we = 2'b00;
        drive(2'b01, 1'b1, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("rd_gnt", host_gnt, 2'b01);
        check("rd_we", dev_we, 0);
        check("wr_resp_rvalid", host_rvalid, 2'b10);
        check("wr_resp_err", host_err, 2'b00);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b1);
        @(negedge clk);
        check("rd_resp_rvalid", host_rvalid, 2'b01);
        check("rd_resp_err", host_err, 2'b01);
        next_cycle();
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("err_busy_clear", busy, 0);
        next_cycle();

        // Unexpected response on an empty FIFO
        drive(2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("unx_rvalid", host_rvalid, 0);
        next_cycle();
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("unx_set", unexp, 1);
        repeat (3) next_cycle();
        @(negedge clk);
        check("unx_sticky", unexp, 1);
        next_cycle();

        // Two outstanding with prio at 1, then reset mid-operation
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rs_second_gnt", host_gnt, 2'b01);
        next_cycle();
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("rs_busy", busy, 0);
        check("rs_unexp", unexp, 0);
        next_cycle();
        rst_ni = 1'b1;
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rs_prio_gnt", host_gnt, 2'b01);
        next_cycle();
        drive(2'b01, 1'b1, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("rs_solo_gnt", host_gnt, 2'b01);
        check("rs_resp", host_rvalid, 2'b01);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        next_cycle();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        next_cycle();
        drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rs_post_unexp", unexp, 1);
        check("rs_post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
